// File: rtl/sram_port_arbiter_if.sv
// Two-requester SRAM arbiter bus: both request ports plus the SRAM side.
// slave = arbiter view, master = requesters/SRAM environment view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int MW = DATA_W / 8;

  logic              p0_req_i;
  logic              p0_lock_i;
  logic              p0_we_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_wdata_i;
  logic [MW-1:0]     p0_wmask_i;
  logic              p0_gnt_o;
  logic              p0_rvalid_o;
  logic [DATA_W-1:0] p0_rdata_o;

  logic              p1_req_i;
  logic              p1_lock_i;
  logic              p1_we_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_wdata_i;
  logic [MW-1:0]     p1_wmask_i;
  logic              p1_gnt_o;
  logic              p1_rvalid_o;
  logic [DATA_W-1:0] p1_rdata_o;

  logic              sram_csb_o;
  logic              sram_web_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_wdata_o;
  logic [MW-1:0]     sram_wmask_o;
  logic [DATA_W-1:0] sram_rdata_i;

  modport slave (
    input  p0_req_i, p0_lock_i, p0_we_i,
    input  p0_addr_i, p0_wdata_i, p0_wmask_i,
    output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
    input  p1_req_i, p1_lock_i, p1_we_i,
    input  p1_addr_i, p1_wdata_i, p1_wmask_i,
    output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
    output sram_csb_o, sram_web_o, sram_addr_o,
    output sram_wdata_o, sram_wmask_o,
    input  sram_rdata_i
  );

  modport master (
    output p0_req_i, p0_lock_i, p0_we_i,
    output p0_addr_i, p0_wdata_i, p0_wmask_i,
    input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
    output p1_req_i, p1_lock_i, p1_we_i,
    output p1_addr_i, p1_wdata_i, p1_wmask_i,
    input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
    input  sram_csb_o, sram_web_o, sram_addr_o,
    input  sram_wdata_o, sram_wmask_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port SRAM arbiter: round-robin with lockable bursts (MAX_BURST).
// Ports: clk_i, rst_ni, bus (slave). Option: SRAM_ARB_FIXED_PRIO_EN.
module sram_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  sram_port_arbiter_if.slave bus
);
  localparam int MW = DATA_W / 8;
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  rpend_q, rpend_d;
  logic        gnt0, gnt1;

  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] wdata_w;
  logic [MW-1:0]     wmask_w;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.p0_req_i && bus.p1_req_i) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          gnt1 = 1'b1;
`else
          // last_q names the previous winner
          gnt0 = last_q;
          gnt1 = !last_q;
`endif
        end else begin
          gnt0 = bus.p0_req_i;
          gnt1 = bus.p1_req_i;
        end
        // a one-grant burst budget leaves nothing to lock
        if (MAXB > 8'd1) begin
          if (gnt0 && bus.p0_lock_i) begin
            state_d = OWN0;
            cnt_d   = 8'd1;
          end
          if (gnt1 && bus.p1_lock_i) begin
            state_d = OWN1;
            cnt_d   = 8'd1;
          end
        end
      end
      OWN0: begin
        gnt0 = bus.p0_req_i;
        cnt_d = cnt_q + 8'd1;
        if (!bus.p0_req_i || !bus.p0_lock_i
            || cnt_d == MAXB) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      OWN1: begin
        gnt1 = bus.p1_req_i;
        cnt_d = cnt_q + 8'd1;
        if (!bus.p1_req_i || !bus.p1_lock_i
            || cnt_d == MAXB) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // keep the SRAM deselected while reset is held
    if (!rst_ni) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    rpend_d = {gnt1 & !bus.p1_we_i, gnt0 & !bus.p0_we_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      rpend_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rpend_q <= rpend_d;
    end
  end

  always_comb begin
    addr_w  = '0;
    wdata_w = '0;
    wmask_w = '0;
    if (gnt0) begin
      addr_w  = bus.p0_addr_i;
      wdata_w = bus.p0_wdata_i;
      wmask_w = bus.p0_wmask_i;
    end else if (gnt1) begin
      addr_w  = bus.p1_addr_i;
      wdata_w = bus.p1_wdata_i;
      wmask_w = bus.p1_wmask_i;
    end
  end

  assign bus.p0_gnt_o     = gnt0;
  assign bus.p1_gnt_o     = gnt1;
  assign bus.sram_csb_o   = !(gnt0 | gnt1);
  assign bus.sram_web_o   = gnt0 ? !bus.p0_we_i
                          : gnt1 ? !bus.p1_we_i : 1'b1;
  assign bus.sram_addr_o  = addr_w;
  assign bus.sram_wdata_o = wdata_w;
  assign bus.sram_wmask_o = wmask_w;

  assign bus.p0_rvalid_o = rpend_q[0];
  assign bus.p1_rvalid_o = rpend_q[1];
  assign bus.p0_rdata_o  = rpend_q[0] ? bus.sram_rdata_i : '0;
  assign bus.p1_rdata_o  = rpend_q[1] ? bus.sram_rdata_i : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level arbitration and memory model.
module tb_sram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!bus.sram_csb_o) begin
      if (!bus.sram_web_o) begin
        for (int b = 0; b < MW; b++)
          if (bus.sram_wmask_o[b])
            mem[bus.sram_addr_o][b*8 +: 8] <=
              bus.sram_wdata_o[b*8 +: 8];
      end else begin
        bus.sram_rdata_i <= mem[bus.sram_addr_o];
      end
    end
  end

  bit            rq [2];
  bit            lk [2];
  bit            we [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic [MW-1:0] wm [2];

  int            owner;
  int            run;
  int            last;
  bit            exp_rv [2];
  logic [DW-1:0] exp_rd [2];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    run = 0;
    last = 1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
  endtask

  task automatic drive();
    bus.p0_req_i   = rq[0];
    bus.p0_lock_i  = lk[0];
    bus.p0_we_i    = we[0];
    bus.p0_addr_i  = ad[0];
    bus.p0_wdata_i = wd[0];
    bus.p0_wmask_i = wm[0];
    bus.p1_req_i   = rq[1];
    bus.p1_lock_i  = lk[1];
    bus.p1_we_i    = we[1];
    bus.p1_addr_i  = ad[1];
    bus.p1_wdata_i = wd[1];
    bus.p1_wmask_i = wm[1];
  endtask

  task automatic set_port(int p, bit r, bit l, bit w,
                          int a, logic [DW-1:0] d,
                          logic [MW-1:0] m);
    rq[p] = r;
    lk[p] = l;
    we[p] = w;
    ad[p] = AW'(a);
    wd[p] = d;
    wm[p] = m;
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model.
  task automatic step(output bit g0, output bit g1);
    int w;
    bit nrv [2];
    logic [DW-1:0] nrd [2];
    drive();
    #2;
    w = -1;
    if (owner >= 0) begin
      if (rq[owner]) w = owner;
    end else if (rq[0] && rq[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      w = 1;
`else
      w = (last == 0) ? 1 : 0;
`endif
    end else if (rq[0]) begin
      w = 0;
    end else if (rq[1]) begin
      w = 1;
    end

    g0 = bus.p0_gnt_o;
    g1 = bus.p1_gnt_o;
    chk("p0_gnt", 64'(bus.p0_gnt_o), 64'(w == 0));
    chk("p1_gnt", 64'(bus.p1_gnt_o), 64'(w == 1));
    chk("csb", 64'(bus.sram_csb_o), 64'(w < 0));
    if (w >= 0) begin
      chk("web", 64'(bus.sram_web_o), 64'(!we[w]));
      chk("addr", 64'(bus.sram_addr_o), 64'(ad[w]));
      chk("wdata", 64'(bus.sram_wdata_o), 64'(wd[w]));
      chk("wmask", 64'(bus.sram_wmask_o), 64'(wm[w]));
    end else begin
      chk("web_idle", 64'(bus.sram_web_o), 64'd1);
      chk("addr_idle", 64'(bus.sram_addr_o), 64'd0);
      chk("wdata_idle", 64'(bus.sram_wdata_o), 64'd0);
    end
    chk("p0_rvalid", 64'(bus.p0_rvalid_o), 64'(exp_rv[0]));
    chk("p1_rvalid", 64'(bus.p1_rvalid_o), 64'(exp_rv[1]));
    chk("p0_rdata", 64'(bus.p0_rdata_o),
        exp_rv[0] ? 64'(exp_rd[0]) : 64'd0);
    chk("p1_rdata", 64'(bus.p1_rdata_o),
        exp_rv[1] ? 64'(exp_rd[1]) : 64'd0);

    nrv[0] = 1'b0;
    nrv[1] = 1'b0;
    nrd[0] = '0;
    nrd[1] = '0;
    if (w >= 0) begin
      if (we[w]) begin
        for (int b = 0; b < MW; b++)
          if (wm[w][b])
            ref_mem[ad[w]][b*8 +: 8] = wd[w][b*8 +: 8];
      end else begin
        nrv[w] = 1'b1;
        nrd[w] = ref_mem[ad[w]];
      end
      last = w;
    end
    if (owner >= 0) begin
      if (w < 0) begin
        owner = -1;
      end else begin
        run++;
        if (!lk[w] || run >= MB) owner = -1;
      end
    end else if (w >= 0 && lk[w] && MB > 1) begin
      owner = w;
      run = 1;
    end
    exp_rv[0] = nrv[0];
    exp_rv[1] = nrv[1];
    exp_rd[0] = nrd[0];
    exp_rd[1] = nrd[1];
    @(negedge clk);
  endtask

  task automatic idle_ports();
    set_port(0, 0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, 0, '0, '0);
  endtask

  bit g0, g1;
  int n1;
  bit seen0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    bus.sram_rdata_i = '0;
    model_reset();
    set_port(0, 1, 0, 0, 'h010, '0, '0);
    set_port(1, 1, 0, 0, 'h020, '0, '0);
    drive();
    #12;
    chk("rst_p0_gnt", 64'(bus.p0_gnt_o), 64'd0);
    chk("rst_p1_gnt", 64'(bus.p1_gnt_o), 64'd0);
    chk("rst_csb", 64'(bus.sram_csb_o), 64'd1);
    chk("rst_web", 64'(bus.sram_web_o), 64'd1);
    chk("rst_addr", 64'(bus.sram_addr_o), 64'd0);
    chk("rst_rvalid", 64'({bus.p0_rvalid_o, bus.p1_rvalid_o}), 64'd0);
    chk("rst_rdata", 64'(bus.p0_rdata_o | bus.p1_rdata_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // both ports read every cycle: tie-break alternates
    for (int i = 0; i < 6; i++) step(g0, g1);
    idle_ports();
    step(g0, g1);
    step(g0, g1);

    // write then read back on the other port
    set_port(0, 1, 0, 1, 'h005, 32'hDEAD_BEEF, 4'hF);
    step(g0, g1);
    idle_ports();
    set_port(1, 1, 0, 0, 'h005, '0, '0);
    step(g0, g1);
    chk("wr_rd_rvalid", 64'(bus.p1_rvalid_o), 64'd1);
    chk("wr_rd_rdata", 64'(bus.p1_rdata_o), 64'hDEAD_BEEF);
    idle_ports();
    step(g0, g1);

    // p1 locked burst against a waiting p0
    set_port(0, 1, 0, 0, 'h030, '0, '0);
    step(g0, g1);
    set_port(1, 1, 1, 0, 'h040, '0, '0);
    n1 = 0;
    seen0 = 1'b0;
    for (int i = 0; i < MB + 1; i++) begin
      step(g0, g1);
      if (g1 && !seen0) n1++;
      if (g0) seen0 = 1'b1;
    end
`ifndef SRAM_ARB_FIXED_PRIO_EN
    chk("burst_p1_len", 64'(n1), 64'(MB));
    chk("burst_then_p0", 64'(seen0), 64'd1);
`endif
    idle_ports();
    step(g0, g1);

    // p0 locked, drops lock on its third grant
    set_port(1, 1, 0, 0, 'h050, '0, '0);
    step(g0, g1);
    idle_ports();
    set_port(0, 1, 1, 0, 'h060, '0, '0);
    set_port(1, 1, 0, 0, 'h070, '0, '0);
    step(g0, g1);
    step(g0, g1);
    lk[0] = 1'b0;
    step(g0, g1);
    step(g0, g1);
`ifndef SRAM_ARB_FIXED_PRIO_EN
    chk("unlock_p1_gnt", 64'(g1), 64'd1);
`endif
    idle_ports();
    step(g0, g1);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    set_port(0, 1, 0, 0, 'h010, '0, '0);
    set_port(1, 1, 0, 0, 'h020, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step(g0, g1);
      chk("fixed_p1", 64'({g0, g1}), 64'b01);
    end
    idle_ports();
    step(g0, g1);
`endif

    // reset lands the cycle after a granted read
    set_port(0, 1, 0, 0, 'h020, '0, '0);
    step(g0, g1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(bus.p0_rvalid_o), 64'd0);
    chk("midrst_csb", 64'(bus.sram_csb_o), 64'd1);
    chk("midrst_gnt", 64'(bus.p0_gnt_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_ports();
    step(g0, g1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15),
                 $urandom, MW'($urandom));
      step(g0, g1);
    end
    idle_ports();
    step(g0, g1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
